// File: rtl/sobel_window_gen_if.sv
// Pixel-stream input and 3x3 window output bundle for sobel_window_gen.
// The slave side is the window generator; the master side feeds pixels and consumes windows.
interface sobel_window_gen_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  logic                          in_valid;
  logic                          in_sof;
  logic [7:0]                    in_pixel;
  logic [7:0]                    p0, p1, p2;
  logic [7:0]                    p3, p4, p5;
  logic [7:0]                    p6, p7, p8;
  logic                          win_valid;
  logic [$clog2(IMG_HEIGHT)-1:0] win_row;
  logic [$clog2(IMG_WIDTH)-1:0]  win_col;
  logic                          frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  p0, p1, p2, p3, p4, p5, p6, p7, p8,
    input  win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output p0, p1, p2, p3, p4, p5, p6, p7, p8,
    output win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one registered window per accepted pixel once a full neighbourhood exists.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic              clk,
  input logic              reset,
  sobel_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, cur_col, next_col;
  logic [RW-1:0] row, cur_row, next_row;
  logic          accept, sof, win_hit, last_pix;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [7:0]    win [9];

  // A start-of-frame pixel is placed at (0,0) no matter where the counters were.
  always_comb begin
    accept   = bus.in_valid;
    sof      = bus.in_valid && bus.in_sof;
    cur_col  = sof ? '0 : col;
    cur_row  = sof ? '0 : row;
    next_col = cur_col + 1'b1;
    next_row = cur_row;
    if (cur_col == LAST_COL) begin
      next_col = '0;
      next_row = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
    end
    win_hit  = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    last_pix = accept && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
  end

  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  // Line buffers are pure storage; every location is rewritten before it is read back.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= bus.in_pixel;
      lb1[cur_col] <= lb0_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col            <= '0;
      row            <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.win_row    <= '0;
      bus.win_col    <= '0;
    end else begin
      bus.win_valid  <= win_hit;
      bus.frame_done <= last_pix;
      if (accept) begin
        col    <= next_col;
        row    <= next_row;
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= bus.in_pixel;
      end
      // Coordinates only move on qualifying pixels so they keep naming the last window.
      if (win_hit) begin
        bus.win_row <= cur_row - 1'b1;
        bus.win_col <= cur_col - 1'b1;
      end
    end
  end

  assign bus.p0 = win[0];
  assign bus.p1 = win[1];
  assign bus.p2 = win[2];
  assign bus.p3 = win[3];
  assign bus.p4 = win[4];
  assign bus.p5 = win[5];
  assign bus.p6 = win[6];
  assign bus.p7 = win[7];
  assign bus.p8 = win[8];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 ramp image (pixel = row*16 + col).
module tb_sobel_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  sobel_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [71:0] obs_win;
  assign obs_win = {bus.p0, bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8};

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c);
    return {px(r-2, c-2), px(r-2, c-1), px(r-2, c),
            px(r-1, c-2), px(r-1, c-1), px(r-1, c),
            px(r,   c-2), px(r,   c-1), px(r,   c)};
  endfunction

  // Drives one pixel across a rising edge; outputs are sampled 1 ns later by the caller.
  task automatic send(input logic [7:0] pix, input logic sof);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_pixel = pix;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_win !== 72'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_window got %h want 0", obs_win);
    end
    n_checks++;
    if ({bus.win_valid, bus.frame_done, bus.win_row, bus.win_col} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl got v=%b fd=%b r=%0d c=%0d want all 0",
               bus.win_valid, bus.frame_done, bus.win_row, bus.win_col);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    int wins = 0;
    logic [1:0] er;
    logic [2:0] ec;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(px(r, c), (r == 0 && c == 0));
        n_checks++;
        if (bus.win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("[TB] FAIL ramp_valid at (%0d,%0d) got %b", r, c, bus.win_valid);
        end
        n_checks++;
        if (bus.frame_done !== (r == H-1 && c == W-1)) begin
          n_fail++;
          $display("[TB] FAIL ramp_frame_done at (%0d,%0d) got %b", r, c, bus.frame_done);
        end
        if (r >= 2 && c >= 2) begin
          wins++;
          er = 2'(r - 1);
          ec = 3'(c - 1);
          n_checks++;
          if (obs_win !== exp_win(r, c) || bus.win_row !== er || bus.win_col !== ec) begin
            n_fail++;
            $display("[TB] FAIL ramp_window at (%0d,%0d) got %h r%0d c%0d want %h r%0d c%0d",
                     r, c, obs_win, bus.win_row, bus.win_col, exp_win(r, c), er, ec);
          end
        end
        if (r == 2 && c == 2) begin
          n_checks++;
          if (obs_win !== 72'h00_01_02_10_11_12_20_21_22 || bus.win_row !== 2'd1 || bus.win_col !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL ramp_first_window got %h r%0d c%0d want 000102101112202122 r1 c1",
                     obs_win, bus.win_row, bus.win_col);
          end
        end
        if (r == 3 && c == 4) begin
          n_checks++;
          if (obs_win !== 72'h12_13_14_22_23_24_32_33_34 || bus.win_row !== 2'd2 ||
              bus.win_col !== 3'd3 || bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ramp_last_window got %h r%0d c%0d fd%b want 121314222324323334 r2 c3 fd1",
                     obs_win, bus.win_row, bus.win_col, bus.frame_done);
          end
        end
      end
    end
    n_checks++;
    if (wins != 6) begin
      n_fail++;
      $display("[TB] FAIL ramp_count got %0d want 6", wins);
    end
  endtask

  task automatic test_gaps();
    int wins = 0;
    int gap;
    logic [71:0] held_win;
    logic [1:0]  held_row;
    logic [2:0]  held_col;
    held_win = obs_win;
    held_row = bus.win_row;
    held_col = bus.win_col;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          n_checks++;
          if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || obs_win !== held_win ||
              bus.win_row !== held_row || bus.win_col !== held_col) begin
            n_fail++;
            $display("[TB] FAIL gap_hold before (%0d,%0d) got v%b fd%b %h want v0 fd0 %h",
                     r, c, bus.win_valid, bus.frame_done, obs_win, held_win);
          end
        end
        send(px(r, c), (r == 0 && c == 0));
        n_checks++;
        if (bus.win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("[TB] FAIL gap_valid at (%0d,%0d) got %b", r, c, bus.win_valid);
        end
        if (r >= 2 && c >= 2) begin
          wins++;
          n_checks++;
          if (obs_win !== exp_win(r, c)) begin
            n_fail++;
            $display("[TB] FAIL gap_window at (%0d,%0d) got %h want %h", r, c, obs_win, exp_win(r, c));
          end
        end
        held_win = obs_win;
        held_row = bus.win_row;
        held_col = bus.win_col;
      end
    end
    n_checks++;
    if (wins != 6) begin
      n_fail++;
      $display("[TB] FAIL gap_count got %0d want 6", wins);
    end
  endtask

  task automatic test_back_to_back();
    int wins = 0;
    int dones = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          send(px(r, c), (f == 0 && r == 0 && c == 0));
          n_checks++;
          if (bus.win_valid !== (r >= 2 && c >= 2)) begin
            n_fail++;
            $display("[TB] FAIL b2b_valid frame %0d at (%0d,%0d) got %b", f, r, c, bus.win_valid);
          end
          if (bus.frame_done === 1'b1) dones++;
          if (r >= 2 && c >= 2) begin
            wins++;
            n_checks++;
            if (obs_win !== exp_win(r, c)) begin
              n_fail++;
              $display("[TB] FAIL b2b_window frame %0d at (%0d,%0d) got %h want %h",
                       f, r, c, obs_win, exp_win(r, c));
            end
          end
        end
      end
    end
    n_checks++;
    if (wins != 12 || dones != 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_count got %0d windows %0d done want 12 and 2", wins, dones);
    end
  endtask

  task automatic test_sof_restart();
    int wins = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 2) ? 3 : W); c++) send(px(r, c), (r == 0 && c == 0));
    end
    n_checks++;
    if (bus.win_valid !== 1'b1 || obs_win !== exp_win(2, 2)) begin
      n_fail++;
      $display("[TB] FAIL restart_pre_window got v%b %h want v1 %h", bus.win_valid, obs_win, exp_win(2, 2));
    end
    send(px(0, 0), 1'b1);
    n_checks++;
    if (bus.win_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_sof_valid got %b want 0", bus.win_valid);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = ((r == 0) ? 1 : 0); c < W; c++) begin
        send(px(r, c), 1'b0);
        n_checks++;
        if (bus.win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("[TB] FAIL restart_valid at (%0d,%0d) got %b", r, c, bus.win_valid);
        end
        if (r >= 2 && c >= 2) begin
          wins++;
          n_checks++;
          if (obs_win !== exp_win(r, c)) begin
            n_fail++;
            $display("[TB] FAIL restart_window at (%0d,%0d) got %h want %h", r, c, obs_win, exp_win(r, c));
          end
        end
      end
    end
    n_checks++;
    if (wins != 6) begin
      n_fail++;
      $display("[TB] FAIL restart_count got %0d want 6", wins);
    end
  endtask

  task automatic test_reset_mid();
    int wins = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < ((r == 3) ? 2 : W); c++) send(px(r, c), (r == 0 && c == 0));
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_win !== 72'h0 || {bus.win_valid, bus.frame_done, bus.win_row, bus.win_col} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset got %h v%b fd%b r%0d c%0d want all 0",
               obs_win, bus.win_valid, bus.frame_done, bus.win_row, bus.win_col);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(px(r, c), 1'b0);
        n_checks++;
        if (bus.win_valid !== (r >= 2 && c >= 2)) begin
          n_fail++;
          $display("[TB] FAIL post_reset_valid at (%0d,%0d) got %b", r, c, bus.win_valid);
        end
        if (r >= 2 && c >= 2) begin
          wins++;
          n_checks++;
          if (obs_win !== exp_win(r, c)) begin
            n_fail++;
            $display("[TB] FAIL post_reset_window at (%0d,%0d) got %h want %h", r, c, obs_win, exp_win(r, c));
          end
        end
      end
    end
    n_checks++;
    if (wins != 6) begin
      n_fail++;
      $display("[TB] FAIL post_reset_count got %0d want 6", wins);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_sof_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
